// File: rtl/synaptic_current.sv
// ============================================================================
// Module   : synaptic_current
// Brief    : Spike FIFO + leaky Q16.16 accumulator producing neuron input current.
//            Optional macro SYN_SATURATE_EN selects saturating (vs wrapping) accumulation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module synaptic_current #(
    parameter int N         = 32,
    parameter int DEPTH     = 4,
    parameter int TAU_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spk_valid,
    output logic                       spk_ready,
    input  logic [N-1:0]               spk_weight,
    input  logic                       step,
    output logic [N-1:0]               I_out,
    output logic                       I_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_DECAY   = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    state_t                state_q;
    logic [N-1:0]          mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [CW-1:0]         k_q;
    logic signed [N-1:0]   acc_q;
    logic signed [N-1:0]   acc_sum_d;
    logic signed [N-1:0]   acc_decay_d;
    logic signed [N-1:0]   head;
    logic [N-1:0]          I_out_q;
    logic                  I_valid_q;
    logic                  overrun_q;
    logic                  step_pending_q;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign full       = (count_q == CW'(DEPTH));
    assign spk_ready  = !full;
    assign push       = spk_valid && !full;
    assign pop        = (state_q == S_DRAIN);
    assign head       = mem_q[rd_ptr_q];
    assign I_out      = I_out_q;
    assign I_valid    = I_valid_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
    end

`ifdef SYN_SATURATE_EN
    logic signed [N:0] acc_wide;
    always_comb begin
        acc_wide = {acc_q[N-1], acc_q} + {head[N-1], head};
        // Top two bits disagree only on overflow; clamp toward the sign of the true sum.
        if (acc_wide[N] != acc_wide[N-1]) begin
            acc_sum_d = acc_wide[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            acc_sum_d = acc_wide[N-1:0];
        end
    end
`else
    always_comb begin
        acc_sum_d = acc_q + head;
    end
`endif

    always_comb begin
        acc_decay_d = acc_q - (acc_q >>> TAU_SHIFT);
    end

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= spk_weight;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            k_q            <= '0;
            acc_q          <= '0;
            I_out_q        <= '0;
            I_valid_q      <= 1'b0;
            overrun_q      <= 1'b0;
            step_pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            I_valid_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (step || step_pending_q) begin
                        // Snapshot includes this edge's push; later pushes wait for the next step.
                        step_pending_q <= 1'b0;
                        k_q            <= count_d;
                        state_q        <= (count_d != '0) ? S_DRAIN : S_DECAY;
                    end
                end
                S_DRAIN: begin
                    acc_q <= acc_sum_d;
                    k_q   <= k_q - CW'(1);
                    if (k_q == CW'(1)) begin
                        state_q <= S_DECAY;
                    end
                end
                S_DECAY: begin
                    acc_q   <= acc_decay_d;
                    state_q <= S_PUBLISH;
                end
                S_PUBLISH: begin
                    I_out_q   <= acc_q;
                    I_valid_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (step && (state_q != S_IDLE)) begin
                if (step_pending_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    step_pending_q <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/synaptic_current.md
Name: synaptic_current

Overview:
- Receiving end of the neuron spike path: consumes weighted presynaptic spike events and produces the signed Q16.16 input current I for the neuron integrator (1.0 = 0x0001_0000).
- Buffers spikes in a small FIFO. On each integration step (dt = 1/8 ms) it folds the buffered weights into an accumulator, applies exponential decay, then publishes I.

Parameters:
- N, 32, data width of weights, accumulator and I_out (Q16.16 when 32).
- DEPTH, 4, spike FIFO entries; power of two, minimum 2.
- TAU_SHIFT, 3, per-step decay shift: acc -= acc >>> TAU_SHIFT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- spk_valid  in  1  spike event offered.
- spk_ready  out  1  FIFO can accept; equals !full.
- spk_weight  in  N  signed synaptic weight, Q16.16.
- step  in  1  one-cycle integration-step strobe.
- I_out  out  N  signed synaptic current, Q16.16.
- I_valid  out  1  one-cycle pulse when I_out updates.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky flag: step lost.

Behaviour:
- Reset (async, rst_n low): FIFO empty, acc = 0, I_out = 0, I_valid = 0, overrun = 0, step_pending = 0, state = IDLE. spk_ready = 1 after reset.
- Push: on an edge where spk_valid && spk_ready, spk_weight is written to the FIFO tail.
  - When full, spk_ready = 0 even if a pop occurs in the same cycle.
  - When not full, push and pop in the same cycle are legal; count is unchanged.
- States: IDLE, DRAIN, DECAY, PUBLISH.
- IDLE: on step (or step_pending) at edge E0:
  - Snapshot k = count after E0's push; clear step_pending.
  - Go to DRAIN if k > 0, otherwise DECAY.
- DRAIN: one pop per cycle for exactly k cycles; acc = sat(acc + head). Spikes pushed during DRAIN stay for the next step. Then go to DECAY.
- DECAY: one cycle; acc = acc - (acc >>> TAU_SHIFT), arithmetic shift (floor). Go to PUBLISH.
- PUBLISH: I_out <= acc and I_valid = 1 for exactly one cycle. Go to IDLE.
- Latency: I_valid is high in the cycle after edge E0+k+2. I_out holds its value between publishes.
- Step while not IDLE:
  - If step_pending = 0, set it; the pending step is serviced from IDLE on the cycle after PUBLISH.
  - If already set, set overrun (sticky until reset).
- Arithmetic: accumulate in N+1 bits. sat() clamps to [-2^(N-1), 2^(N-1)-1] (see Optional Feature). The decay step never overflows.
- Reset mid-operation: every state, FIFO content and acc are discarded immediately; no I_valid is emitted.

Optional Feature:
- Macro SYN_SATURATE_EN.
- Defined: sat() clamps as above.
- Undefined: plain N-bit two's-complement wrap, with no extra adder bit.
- All other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-DRAIN with 3 entries queued -> immediately count = 0, I_out = 0, spk_ready = 1. Next step publishes I_out = 0.
- Single spike: push weight 0x0001_0000, then step -> I_valid 3 cycles after the step edge with I_out = 0x0000_E000. Next step with no spikes -> I_out = 0x0000_C400, 2 cycles after the step edge.
- FIFO full: push 4 spikes with no step -> count = 4, spk_ready = 0, 5th offer not accepted. Step -> drains 4 entries, I_valid at E0+6.
- Push during DRAIN: 2 queued, step, push 1 during DRAIN -> publish includes only the first 2; count = 1 after PUBLISH.
- Saturation: two weights 0x7000_0000, then step.
  - With SYN_SATURATE_EN: I_out = 0x7000_0000 (0x7FFF_FFFF decayed).
  - Without SYN_SATURATE_EN: I_out = 0xE400_0000.
- Overrun: a step in DRAIN sets pending and is serviced after PUBLISH (second I_valid). A further step while pending sets overrun = 1, held until reset.
